// File: rtl/i2c_req_arbiter.sv
// Purpose: round-robin front end sharing one sda_generate I2C master FSM
//          between NUM_REQ requesters. It latches the winner's operands,
//          launches the master, then reports done/err and read bytes.
// Latency: req sampled in IDLE on edge N gives grant/m_start from N+1.
//          m_free seen high in BUSY on edge M gives done/err/rd_data in M+1.
// Backpressure: a level req is held until done. Arbitration waits for m_free=1.
// Ports:   clk/rst_n (async active-low); req/req_* packed per requester;
//          grant/done/err one-hot per requester; rd_data1/2 last read bytes;
//          m_* drive the master command inputs; m_free/m_state/m_dout_* come back.
// Option:  define I2C_ARB_TIMEOUT_EN for a LAUNCH/BUSY watchdog of TIMEOUT_CYC clocks.
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_LEN    = 7,
    parameter int DATA_LEN    = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata1,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata2,
    input  logic [NUM_REQ-1:0]           req_ack3p,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic [DATA_LEN-1:0]          rd_data1,
    output logic [DATA_LEN-1:0]          rd_data2,
    output logic                         m_start,
    output logic [ADDR_LEN-1:0]          m_add_reg,
    output logic                         m_R_W,
    output logic [DATA_LEN-1:0]          m_data_1,
    output logic [DATA_LEN-1:0]          m_data_2,
    output logic                         m_ack_3p,
    input  logic                         m_free,
    input  logic [3:0]                   m_state,
    input  logic [DATA_LEN-1:0]          m_dout_1,
    input  logic [DATA_LEN-1:0]          m_dout_2
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Master state codes watched for NACK and byte-count tracking.
    localparam logic [3:0] MS_CHK_ADDR = 4'd3;
    localparam logic [3:0] MS_WR_DATA  = 4'd4;
    localparam logic [3:0] MS_CHK_DATA = 4'd5;
    localparam logic [3:0] MS_RD_DATA  = 4'd6;
    localparam logic [3:0] MS_MST_ACK  = 4'd7;
    localparam logic [3:0] MS_STOP     = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     own, rr, pick;
    logic                 pick_vld;
    logic                 nack;
    logic [1:0]           byte_cnt;
    logic [3:0]           m_state_q;
    logic                 to_hit;
    logic [NUM_REQ-1:0]   own_oh;
    logic [2:0]           bytes_fin;

    // Round-robin pick: first set req at or after rr, wrapping.
    always_comb begin
        logic [IDX_W:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_vld && req[idx[IDX_W-1:0]]) begin
                pick     = idx[IDX_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] to_cnt;

    // Cleared while idle so it starts at 0 on the first LAUNCH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_LAUNCH || state == S_BUSY) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign to_hit = (state == S_LAUNCH || state == S_BUSY) &&
                    (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (m_free && pick_vld) state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                if (to_hit)       state_nxt = S_DONE;
                else if (!m_free) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (to_hit || m_free) state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Owner-facing outputs decode straight from state so they drop with reset.
    always_comb begin
        own_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << own;
        grant   = (state != S_IDLE) ? own_oh : '0;
        done    = (state == S_DONE) ? own_oh : '0;
        err     = (state == S_DONE && nack) ? own_oh : '0;
        m_start = (state == S_LAUNCH);
    end

    // Bytes completed including the one finishing on the move into Stop.
    assign bytes_fin = {1'b0, byte_cnt} +
                       ((m_state_q == MS_CHK_DATA || m_state_q == MS_MST_ACK) ? 3'd1 : 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own       <= '0;
            rr        <= '0;
            nack      <= 1'b0;
            byte_cnt  <= '0;
            m_state_q <= '0;
            m_add_reg <= '0;
            m_R_W     <= 1'b0;
            m_data_1  <= '0;
            m_data_2  <= '0;
            m_ack_3p  <= 1'b0;
            rd_data1  <= '0;
            rd_data2  <= '0;
        end else begin
            m_state_q <= m_state;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LAUNCH) begin
                        own       <= pick;
                        m_add_reg <= req_addr[int'(pick)*ADDR_LEN +: ADDR_LEN];
                        m_R_W     <= req_rw[pick];
                        m_data_1  <= req_wdata1[int'(pick)*DATA_LEN +: DATA_LEN];
                        m_data_2  <= req_wdata2[int'(pick)*DATA_LEN +: DATA_LEN];
                        m_ack_3p  <= req_ack3p[pick];
                        byte_cnt  <= '0;
                        nack      <= 1'b0;
                    end
                end
                S_LAUNCH, S_BUSY: begin
                    if ((m_state_q == MS_CHK_DATA && m_state == MS_WR_DATA) ||
                        (m_state_q == MS_MST_ACK  && m_state == MS_RD_DATA)) begin
                        if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                    end
                    // A stop straight out of an ACK check before two bytes
                    // finished means the slave refused.
                    if (m_state == MS_STOP &&
                        (m_state_q == MS_CHK_ADDR || m_state_q == MS_CHK_DATA) &&
                        bytes_fin < 3'd2) begin
                        nack <= 1'b1;
                    end
                    if (to_hit) begin
                        nack <= 1'b1;
                    end else if (state_nxt == S_DONE && m_R_W) begin
                        rd_data1 <= m_dout_1;
                        rd_data2 <= m_dout_2;
                    end
                end
                S_DONE: begin
                    rr   <= (own == IDX_W'(NUM_REQ - 1)) ? '0 : own + IDX_W'(1);
                    nack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Purpose: directed self-checking bench for i2c_req_arbiter with a scripted master.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the scripted master holds m_free low for the length of each transfer script.
module tb_i2c_req_arbiter;

    localparam int NR = 4;
    localparam int AL = 7;
    localparam int DL = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*AL-1:0] req_addr;
    logic [NR-1:0]   req_rw;
    logic [NR*DL-1:0] req_wdata1, req_wdata2;
    logic [NR-1:0]   req_ack3p;
    logic [NR-1:0]   grant, done, err;
    logic [DL-1:0]   rd_data1, rd_data2;
    logic            m_start;
    logic [AL-1:0]   m_add_reg;
    logic            m_R_W;
    logic [DL-1:0]   m_data_1, m_data_2;
    logic            m_ack_3p;
    logic            m_free;
    logic [3:0]      m_state;
    logic [DL-1:0]   m_dout_1, m_dout_2;

    int total = 0;
    int bad   = 0;

    i2c_req_arbiter #(
        .NUM_REQ(NR), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_wdata1(req_wdata1), .req_wdata2(req_wdata2), .req_ack3p(req_ack3p),
        .grant(grant), .done(done), .err(err),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .m_start(m_start), .m_add_reg(m_add_reg), .m_R_W(m_R_W),
        .m_data_1(m_data_1), .m_data_2(m_data_2), .m_ack_3p(m_ack_3p),
        .m_free(m_free), .m_state(m_state),
        .m_dout_1(m_dout_1), .m_dout_2(m_dout_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for m_start; n = extra falling edges after the first.
    task automatic wait_start(output int n);
        n = 0;
        @(negedge clk);
        while (m_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (n < 20) else begin
            bad++;
            $error("FAIL start_wait: observed=%0d cycles expected=<20", n);
        end
    endtask

    // Scripted master from the LAUNCH cycle to the DONE cycle.
    // kind 0: two-byte write ACKed, 1: two-byte read, 2: address NACK.
    task automatic run_master(input int kind);
        int seq[$];
        case (kind)
            0:       seq = '{2, 3, 4, 5, 4, 5, 8};
            1:       seq = '{2, 3, 6, 7, 6, 7, 8};
            default: seq = '{2, 3, 8};
        endcase
        m_free  = 1'b0;
        m_state = 4'd1;
        @(negedge clk);
        chk("start_width", {31'd0, m_start}, 32'd0);
        foreach (seq[i]) begin
            m_state = seq[i][3:0];
            @(negedge clk);
        end
        m_state = 4'd0;
        m_free  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int cnt;
        rst_n      = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_rw     = '0;
        req_wdata1 = '0;
        req_wdata2 = '0;
        req_ack3p  = '0;
        m_free     = 1'b1;
        m_state    = 4'd0;
        m_dout_1   = '0;
        m_dout_2   = '0;
        repeat (2) @(negedge clk);

        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_start", {31'd0, m_start}, 32'd0);
        chk("rst_done",  {28'd0, done}, 32'd0);
        chk("rst_rd1",   {24'd0, rd_data1}, 32'd0);
        chk("rst_addr",  {25'd0, m_add_reg}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 1.
        req_addr[1*AL +: AL]   = 7'h50;
        req_wdata1[1*DL +: DL] = 8'hA5;
        req_wdata2[1*DL +: DL] = 8'h3C;
        req_rw[1]              = 1'b0;
        req                    = 4'b0010;
        wait_start(n);
        chk("wr_latency", n, 0);
        chk("wr_grant", {28'd0, grant}, 32'h2);
        chk("wr_addr",  {25'd0, m_add_reg}, 32'h50);
        chk("wr_d1",    {24'd0, m_data_1}, 32'hA5);
        chk("wr_d2",    {24'd0, m_data_2}, 32'h3C);
        chk("wr_rw",    {31'd0, m_R_W}, 32'd0);
        m_dout_1 = 8'h77;
        m_dout_2 = 8'h88;
        run_master(0);
        chk("wr_done", {28'd0, done}, 32'h2);
        chk("wr_err",  {28'd0, err}, 32'd0);
        chk("wr_hold", {25'd0, m_add_reg}, 32'h50);
        chk("wr_rd1",  {24'd0, rd_data1}, 32'd0);
        req = '0;
        @(negedge clk);
        chk("wr_idle_grant", {28'd0, grant}, 32'd0);
        chk("wr_done_1cyc",  {28'd0, done}, 32'd0);

        // Read from requester 2, req dropped mid-transfer.
        req_addr[2*AL +: AL] = 7'h21;
        req_rw[2]            = 1'b1;
        req_ack3p[2]         = 1'b1;
        req                  = 4'b0100;
        wait_start(n);
        chk("rd_grant", {28'd0, grant}, 32'h4);
        chk("rd_rw",    {31'd0, m_R_W}, 32'd1);
        chk("rd_ack3p", {31'd0, m_ack_3p}, 32'd1);
        req      = '0;
        m_dout_1 = 8'h12;
        m_dout_2 = 8'h34;
        run_master(1);
        chk("rd_done", {28'd0, done}, 32'h4);
        chk("rd_err",  {28'd0, err}, 32'd0);
        chk("rd_rd1",  {24'd0, rd_data1}, 32'h12);
        chk("rd_rd2",  {24'd0, rd_data2}, 32'h34);
        @(negedge clk);

        // Address NACK on a write from requester 0.
        req_addr[0*AL +: AL] = 7'h3A;
        req_rw[0]            = 1'b0;
        req                  = 4'b0001;
        wait_start(n);
        chk("nk_grant", {28'd0, grant}, 32'h1);
        m_dout_1 = 8'hEE;
        m_dout_2 = 8'hEE;
        run_master(2);
        chk("nk_done", {28'd0, done}, 32'h1);
        chk("nk_err",  {28'd0, err}, 32'h1);
        chk("nk_rd1",  {24'd0, rd_data1}, 32'h12);
        chk("nk_rd2",  {24'd0, rd_data2}, 32'h34);
        req = '0;
        @(negedge clk);

        // Reset during BUSY (rr is 1 here, requester 3 wins).
        req = 4'b1000;
        wait_start(n);
        chk("rs_grant", {28'd0, grant}, 32'h8);
        m_free  = 1'b0;
        m_state = 4'd1;
        @(negedge clk);
        m_state = 4'd2;
        @(negedge clk);
        rst_n   = 1'b0;
        m_state = 4'd0;
        m_free  = 1'b1;
        #1;
        chk("rs_grant_now", {28'd0, grant}, 32'd0);
        chk("rs_start_now", {31'd0, m_start}, 32'd0);
        @(negedge clk);
        chk("rs_done", {28'd0, done}, 32'd0);
        chk("rs_grant_nxt", {28'd0, grant}, 32'd0);
        rst_n = 1'b1;

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(n);
            chk($sformatf("rr_gap%0d", i), n, (i == 0) ? 0 : 1);
            chk($sformatf("rr_grant%0d", i), {28'd0, grant}, 32'd1 << (i % 4));
            run_master(0);
            chk($sformatf("rr_done%0d", i), {28'd0, done}, 32'd1 << (i % 4));
        end
        req = '0;
        @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Stuck master: done/err 64 cycles after LAUNCH.
        req = 4'b0010;
        wait_start(n);
        m_free  = 1'b0;
        m_state = 4'd1;
        req     = '0;
        cnt     = 0;
        while (done === '0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_cycles", cnt, 64);
        chk("to_done",   {28'd0, done}, 32'h2);
        chk("to_err",    {28'd0, err}, 32'h2);
        m_free  = 1'b1;
        m_state = 4'd0;
        @(negedge clk);
`else
        cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
